// File: rtl/sweep_framer_if.sv
// Stream-side bundle of sweep_framer: ramp/sample inputs, byte output
// handshake and status. The framer uses the slave side.
interface sweep_framer_if #(
  parameter int IW    = 12,
  parameter int NCH   = 2,
  parameter int USBDW = 8
) ();
  logic                 sweep_start_i;
  logic                 sample_valid_i;
  logic [NCH*IW-1:0]    sample_i;
  logic [USBDW-1:0]     data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 busy_o;
  logic [15:0]          drop_cnt_o;
  logic                 err_o;

  modport slave (
    input  sweep_start_i, sample_valid_i, sample_i, ready_i,
    output data_o, valid_o, busy_o, drop_cnt_o, err_o
  );

  modport master (
    output sweep_start_i, sample_valid_i, sample_i, ready_i,
    input  data_o, valid_o, busy_o, drop_cnt_o, err_o
  );
endinterface

// File: rtl/sweep_framer.sv
// Captures one header-prefixed frame of NCH-channel samples per sweep into a
// byte-wide store-and-forward FIFO; sweeps that would not fit are dropped whole.
module sweep_framer #(
  parameter int IW         = 12,
  parameter int NCH        = 2,
  parameter int NSAMP      = 256,
  parameter int USBDW      = 8,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sweep_framer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = 2 * NCH;
  localparam int XW = (NB > 4) ? $clog2(NB) : 2;
  localparam int SW = $clog2(NSAMP + 1);
  localparam logic [CW-1:0] FRAME_LEN = CW'(4 + 2 * NCH * NSAMP);
  localparam logic [CW-1:0] DEPTH_L   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, WAIT, SER} state_t;

  state_t            state;
  logic [XW-1:0]     idx;
  logic [SW-1:0]     scnt;
  logic [7:0]        seq;
  logic [7:0]        hseq;
  logic [NCH*IW-1:0] smp;
  logic [15:0]       drop_cnt;
  logic              err;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en;
  logic              rd_en;
  logic              valid;
  logic              room;
  logic [7:0]        wr_byte;

  // Byte b of a latched group: even b is the zero-extended upper part, odd b the low byte.
  function automatic logic [7:0] sample_byte(input logic [NCH*IW-1:0] s,
                                             input logic [XW-1:0] b);
    logic [IW-1:0] v;
    logic [15:0]   z;
    v = s[(int'(b) >> 1) * IW +: IW];
    z = 16'(v);
    return b[0] ? z[7:0] : z[15:8];
  endfunction

  // Reads only ever grow free space, so checking against this cycle's count is safe.
  assign room  = (DEPTH_L - count) >= FRAME_LEN;
  assign valid = (count != '0);
  assign rd_en = valid && bus.ready_i;

  always_comb begin
    wr_en   = 1'b0;
    wr_byte = '0;
    case (state)
      HDR: begin
        wr_en = 1'b1;
        case (idx[1:0])
          2'd0:    wr_byte = 8'hA5;
          2'd1:    wr_byte = 8'h5A;
          2'd2:    wr_byte = hseq;
          default: wr_byte = 8'(NCH);
        endcase
      end
      SER: begin
        wr_en   = 1'b1;
        wr_byte = sample_byte(smp, idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      scnt     <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (bus.sweep_start_i && state != IDLE) err <= 1'b1;
      case (state)
        IDLE: if (bus.sweep_start_i) begin
          seq <= seq + 8'd1;
          if (room) begin
            state <= HDR;
            idx   <= '0;
            scnt  <= '0;
          end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end
        HDR: begin
          if (idx == XW'(3)) begin
            state <= WAIT;
            idx   <= '0;
          end else begin
            idx <= idx + XW'(1);
          end
        end
        WAIT: if (bus.sample_valid_i) begin
          state <= SER;
          idx   <= '0;
        end
        SER: begin
          if (bus.sample_valid_i) err <= 1'b1;
          if (idx == XW'(NB - 1)) begin
            idx   <= '0;
            scnt  <= scnt + SW'(1);
            state <= (scnt == SW'(NSAMP - 1)) ? IDLE : WAIT;
          end else begin
            idx <= idx + XW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame payload registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && bus.sweep_start_i && room) hseq <= seq;
    if (state == WAIT && bus.sample_valid_i)         smp  <= bus.sample_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.data_o     = valid ? USBDW'(mem[rd_ptr]) : '0;
  assign bus.valid_o    = valid;
  assign bus.busy_o     = (state != IDLE);
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.err_o      = err;
endmodule

// File: tb/tb_sweep_framer.sv
// Randomized scoreboard bench for sweep_framer: a frame-level model queues the
// expected byte stream and a monitor checks every byte the DUT hands over.
module tb_sweep_framer;
  localparam int IW    = 12;
  localparam int NCH   = 2;
  localparam int NSAMP = 4;
  localparam int DEPTH = 32;
  localparam int NB    = 2 * NCH;
  localparam int F     = 4 + 2 * NCH * NSAMP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sweep_framer_if #(.IW(IW), .NCH(NCH), .USBDW(8)) bus ();

  sweep_framer #(.IW(IW), .NCH(NCH), .NSAMP(NSAMP), .USBDW(8), .FIFO_DEPTH(DEPTH))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int  tests = 0;
  int  fails = 0;
  byte unsigned q[$];
  int  reads = 0;
  int  accepted_bytes = 0;
  int  seq_m = 0;
  int  drop_m = 0;
  bit  err_m = 1'b0;
  bit  rand_ready = 1'b0;
  int  ready_pct = 100;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  initial begin
    bit           hold_v;
    byte unsigned hold_d;
    hold_v = 1'b0;
    hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && bus.valid_o) chk("hold_stable", int'(bus.data_o), int'(hold_d));
        if (bus.valid_o && bus.ready_i) begin
          reads++;
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stream_extra: actual byte 0x%02h, required no byte", bus.data_o);
          end else begin
            chk("stream_byte", int'(bus.data_o), int'(q.pop_front()));
          end
        end
        hold_v = bus.valid_o && !bus.ready_i;
        hold_d = bus.data_o;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.ready_i = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic model_reset();
    q.delete();
    reads = 0;
    accepted_bytes = 0;
    seq_m = 0;
    drop_m = 0;
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sweep_start_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Frame-level reference: accept iff the frame fits in what is not yet drained.
  task automatic start_sweep(output bit acc);
    int occ;
    occ = accepted_bytes - reads;
    acc = (DEPTH - occ) >= F;
    if (acc) begin
      q.push_back(8'hA5);
      q.push_back(8'h5A);
      q.push_back(8'(seq_m));
      q.push_back(8'(NCH));
      accepted_bytes += F;
    end else if (drop_m < 65535) begin
      drop_m++;
    end
    seq_m = (seq_m + 1) % 256;
    bus.sweep_start_i = 1'b1;
    tick();
    bus.sweep_start_i = 1'b0;
  endtask

  task automatic push_sample(input logic [NCH*IW-1:0] s);
    for (int k = 0; k < NCH; k++) begin
      int v;
      v = int'((s >> (k * IW)) & ((1 << IW) - 1));
      q.push_back(8'(v >> 8));
      q.push_back(8'(v & 255));
    end
  endtask

  // Header cycles; an optional stray sample here must be dropped silently.
  task automatic hdr_cycles(input int n, input bit junk);
    int jp;
    jp = junk ? int'($urandom_range(0, n - 1)) : -1;
    for (int j = 0; j < n; j++) begin
      if (j == jp) begin
        bus.sample_valid_i = 1'b1;
        bus.sample_i = 24'($urandom);
      end
      tick();
      bus.sample_valid_i = 1'b0;
    end
  endtask

  task automatic samples(input int n, input int gapmax, input int ov_pct,
                         input bit use_fixed, input logic [NCH*IW-1:0] fixed);
    for (int s = 0; s < n; s++) begin
      logic [NCH*IW-1:0] v;
      int op;
      v = use_fixed ? fixed : (NCH*IW)'($urandom);
      push_sample(v);
      bus.sample_valid_i = 1'b1;
      bus.sample_i = v;
      tick();
      bus.sample_valid_i = 1'b0;
      op = ($urandom_range(0, 99) < ov_pct) ? int'($urandom_range(0, NB - 1)) : -1;
      if (op >= 0) err_m = 1'b1;
      for (int j = 0; j < NB; j++) begin
        if (j == op) begin
          bus.sample_valid_i = 1'b1;
          bus.sample_i = (NCH*IW)'($urandom);
        end
        tick();
        bus.sample_valid_i = 1'b0;
      end
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
    end
  endtask

  task automatic run_frame(input int gapmax, input int ov_pct, input bit junk,
                           output bit acc);
    start_sweep(acc);
    if (acc) begin
      hdr_cycles(4, junk);
      samples(NSAMP, gapmax, ov_pct, 1'b0, '0);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, int'(bus.busy_o), 0);
    chk({tag, "_drop_cnt"}, int'(bus.drop_cnt_o), drop_m);
    chk({tag, "_err"}, int'(bus.err_o), int'(err_m));
  endtask

  task automatic drain(input string tag);
    int n;
    rand_ready = 1'b0;
    bus.ready_i = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: actual %0d bytes outstanding, required 0", tag, q.size());
    end
    tick();
    chk({tag, "_empty"}, int'(bus.valid_o), 0);
  endtask

  initial begin
    bit acc;
    int r0;
    bus.sweep_start_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    bus.sample_i = '0;
    bus.ready_i = 1'b1;
    do_reset();

    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_drop", int'(bus.drop_cnt_o), 0);
    chk("rst_err", int'(bus.err_o), 0);

    // Single frame with fixed samples, checking first-byte latency.
    start_sweep(acc);
    chk("c1_valid", int'(bus.valid_o), 0);
    chk("c1_busy", int'(bus.busy_o), 1);
    tick();
    chk("c2_valid", int'(bus.valid_o), 1);
    chk("c2_data", int'(bus.data_o), 8'hA5);
    hdr_cycles(3, 1'b0);
    samples(NSAMP, 0, 0, 1'b1, {12'hABC, 12'h123});
    drain("single");
    chk("single_bytes", reads, F);
    check_status("single");

    // Backpressure: whole frame held, head stays A5.
    bus.ready_i = 1'b0;
    r0 = reads;
    run_frame(2, 0, 1'b1, acc);
    repeat (5) tick();
    chk("bp_valid", int'(bus.valid_o), 1);
    chk("bp_head", int'(bus.data_o), 8'hA5);
    chk("bp_no_reads", reads - r0, 0);
    drain("bp");
    chk("bp_bytes", reads - r0, F);

    // Drop: second frame does not fit while the first is held.
    do_reset();
    bus.ready_i = 1'b0;
    run_frame(0, 0, 1'b0, acc);
    start_sweep(acc);
    chk("drop_cnt", int'(bus.drop_cnt_o), 1);
    chk("drop_busy", int'(bus.busy_o), 0);
    tick();
    chk("drop_busy2", int'(bus.busy_o), 0);
    drain("drop");
    run_frame(1, 0, 1'b0, acc);
    drain("after_drop");
    check_status("drop");

    // Start during WAIT: error, seq unchanged.
    do_reset();
    start_sweep(acc);
    hdr_cycles(4, 1'b0);
    samples(1, 0, 0, 1'b0, '0);
    chk("busystart_err_before", int'(bus.err_o), 0);
    bus.sweep_start_i = 1'b1;
    tick();
    bus.sweep_start_i = 1'b0;
    err_m = 1'b1;
    chk("busystart_err_after", int'(bus.err_o), 1);
    samples(NSAMP - 1, 1, 0, 1'b0, '0);
    run_frame(0, 0, 1'b0, acc);
    drain("busystart");

    // Overrun: stray samples during SER are not serialised.
    do_reset();
    run_frame(1, 100, 1'b1, acc);
    drain("overrun");
    check_status("overrun");

    // Randomized traffic with varying backpressure.
    for (int i = 0; i < 40; i++) begin
      int pcts[3];
      pcts = '{15, 60, 100};
      ready_pct = pcts[$urandom_range(0, 2)];
      rand_ready = 1'b1;
      run_frame(3, 30, 1'($urandom_range(0, 1)), acc);
      repeat ($urandom_range(0, 3)) tick();
      check_status("rand");
    end
    drain("rand");

    // Sequence wrap after 256 sweeps.
    do_reset();
    for (int i = 0; i < 256; i++) run_frame(0, 0, 1'b0, acc);
    run_frame(0, 0, 1'b0, acc);
    drain("wrap");
    check_status("wrap");

    // Reset in the middle of SER.
    start_sweep(acc);
    hdr_cycles(4, 1'b0);
    bus.sample_valid_i = 1'b1;
    bus.sample_i = 24'h5A5A5A;
    tick();
    bus.sample_valid_i = 1'b1;
    tick();
    bus.sample_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", int'(bus.valid_o), 0);
    chk("midrst_data", int'(bus.data_o), 0);
    chk("midrst_busy", int'(bus.busy_o), 0);
    chk("midrst_drop", int'(bus.drop_cnt_o), 0);
    chk("midrst_err", int'(bus.err_o), 0);
    rst = 1'b0;
    model_reset();
    run_frame(1, 0, 1'b0, acc);
    drain("recover");
    check_status("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sweep_framer.md
# sweep_framer

Single-clock, parametrised successor to the fixed ADC → FIR → downsample → packer → USB chain. It captures one frame of N-channel downsampled samples per FMCW sweep and prefixes each frame with a header and sequence number. Frames are serialised into a byte-wide store-and-forward FIFO feeding the USB transmit path. A whole sweep is dropped, never truncated, when the FIFO cannot hold it.

## Interface

Parameters:
- IW, 12: sample width; 9 ≤ IW ≤ 16.
- NCH, 2: channel count; 1 ≤ NCH ≤ 8.
- NSAMP, 256: samples per channel per sweep.
- USBDW, 8: output byte width; fixed at 8.
- FIFO_DEPTH, 2048: FIFO depth in bytes; must be a power of 2 and ≥ 4 + 2·NCH·NSAMP.

Ports:
- clk_i, in, 1: sole clock.
- rst_i, in, 1: synchronous, active-high reset.
- sweep_start_i, in, 1: single-cycle pulse marking the start of a ramp.
- sample_valid_i, in, 1: single-cycle strobe; all channels are valid together.
- sample_i, in, NCH·IW: channel k occupies bits [k·IW +: IW].
- data_o, out, USBDW: FIFO head byte.
- valid_o, out, 1: data_o is valid.
- ready_i, in, 1: a byte transfers on a cycle where valid_o && ready_i.
- busy_o, out, 1: FSM is not IDLE.
- drop_cnt_o, out, 16: count of dropped sweeps; saturates at 0xFFFF.
- err_o, out, 1: sticky protocol-error flag.

## Operation

- **Frame format**, in order:
  - 0xA5, 0x5A, seq[7:0], NCH[7:0].
  - Then NSAMP sample groups. Each group is channel 0 through NCH-1. Each sample is sent as two bytes: high byte = zero-extended sample[IW-1:8], then low byte = sample[7:0].
  - Frame length F = 4 + 2·NCH·NSAMP bytes.
- **seq**: an 8-bit counter, reset to 0. It increments on every sweep_start_i seen in IDLE, whether that sweep is accepted or dropped, so the host can detect gaps. It wraps 255 → 0.
- **State machine**:
  - **IDLE**, on sweep_start_i:
    - If FIFO free space ≥ F: the sweep is accepted; go to HDR.
    - Otherwise: the sweep is dropped; drop_cnt_o increments (saturating) and the FSM stays in IDLE.
    - Free space is taken from the occupancy on the same cycle. Concurrent reads only increase space, so the check is safe.
  - **HDR**: writes the 4 header bytes, one per cycle, then goes to WAIT.
  - **WAIT**: on sample_valid_i, latches all NCH samples and goes to SER.
  - **SER**: writes 2·NCH bytes, one per cycle, and increments the sample counter.
    - If the counter has reached NSAMP, go to IDLE.
    - Otherwise go to WAIT.
- **Sample handling outside WAIT**:
  - In IDLE or HDR, sample_valid_i is silently discarded.
  - In SER, sample_valid_i is discarded and sets err_o (overrun). That sample is not counted.
- **sweep_start_i outside IDLE** is ignored, sets err_o, and does not change seq.
- **FIFO**:
  - Show-ahead; data_o always shows the head byte when valid_o is high.
  - A simultaneous read and write leaves occupancy unchanged.
  - A write can never occur while full, by construction of the reservation check.
  - A read when empty is a no-op.
- **Reset mid-frame**: the FIFO is emptied, the partial frame is discarded, and the FSM returns to IDLE.

## Timing

- **Reset values**: data_o = 0, valid_o = 0, busy_o = 0, drop_cnt_o = 0, err_o = 0, seq = 0, FIFO empty, FSM in IDLE.
- **Cycle 0** is an accepted sweep_start_i:
  - HDR writes on cycles 1–4.
  - With an empty FIFO, valid_o rises on cycle 2 with data_o = 0xA5.
- **Busy window**: busy_o is high from cycle 1 until the cycle after the last SER write.
- **Sample latch**: a sample_valid_i on cycle t in WAIT is latched at t. SER writes occur on cycles t+1 … t+2·NCH.
- **Minimum spacing**: the earliest next accepted sample_valid_i is at t+2·NCH+1. Upstream guarantees this spacing.
- **Throughput**: write bandwidth is 1 byte/cycle. Read bandwidth is 1 byte/cycle while ready_i is high.
- **Output handshake**: data_o must remain stable while valid_o && !ready_i.
- **Counter timing**: drop_cnt_o and err_o update on the cycle after the triggering event.

## Test plan

- **Single frame** (NCH=2, NSAMP=4, IW=12, ready_i=1): pulse start, then 4 samples (0x123, 0xABC) spaced 5 cycles apart. Required stream: A5 5A 00 02, then (01 23 0A BC) ×4. That is F=20 bytes; valid_o rises 2 cycles after start.
- **Backpressure**: hold ready_i=0 for the whole frame. Required: all 20 bytes are retained; data_o stays 0xA5 and stable while ready_i is low. After ready_i=1, 20 bytes drain in order.
- **Drop**: with FIFO_DEPTH=32, fill one frame with ready_i=0, then pulse a second start. Required: drop_cnt_o=1 and busy_o stays 0. After draining, a third start is accepted with seq=0x02.
- **Overrun**: issue sample_valid_i during SER. Required: err_o=1 and the sample is absent from the stream. The frame completes only after NSAMP accepted samples.
- **Busy start / wrap / reset**:
  - A start pulse during WAIT sets err_o and leaves seq unchanged.
  - 256 accepted sweeps make seq wrap to 0x00.
  - Asserting rst_i mid-SER produces valid_o=0 the next cycle, with all outputs at reset values.
